// File: rtl/arithm_seq_pkg.sv
// Shared ALU constants for the multi-cycle arithmetic unit: opcodes, FSM encodings,
// the result flag bundle and small opcode classification helpers.
package arithm_seq_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_MUL_L = 3'b010;
    localparam logic [2:0] ALU_MUL_H = 3'b011;
    localparam logic [2:0] ALU_DIV   = 3'b100;
    localparam logic [2:0] ALU_REM   = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic cf;
        logic ovf;
        logic dz;
    } flags_t;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == ALU_MUL_L) || (op == ALU_MUL_H);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/arithm_seq_if.sv
// Request/response bundle between the opcode decoder, the arithmetic unit and writeback.
interface arithm_seq_if #(
    parameter int WIDTH = 32
);
    // Request transfers on a rising edge where i_valid && o_ready; o_ready is high only when
    // idle. o_valid is a one-cycle pulse with no back-pressure; o_data/flags hold until the next.
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_cf;
    logic             o_ovf;
    logic             o_dz;

    modport slave (
        input  i_valid, i_op, i_a, i_b,
        output o_ready, o_valid, o_data, o_cf, o_ovf, o_dz
    );

    modport master (
        output i_valid, i_op, i_a, i_b,
        input  o_ready, o_valid, o_data, o_cf, o_ovf, o_dz
    );
endinterface

// File: rtl/arithm_seq_divu.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, WIDTH steps per start.
// quot_o/rem_o are the values after the current step so the caller can capture them on last_o.
module arithm_divu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dz_o
);
    logic [WIDTH-1:0] quot_q, rem_q, div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, dz_q;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;
    logic             ge;

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    always_comb begin
        part   = {rem_q, quot_q[WIDTH-1]};
        diff   = part - {1'b0, div_q};
        ge     = (part >= {1'b0, div_q});
        quot_o = {quot_q[WIDTH-2:0], ge};
        rem_o  = ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    end

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == '0);
    assign dz_o   = dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (start_i) begin
            quot_q <= a_i;
            rem_q  <= '0;
            div_q  <= b_i;
            cnt_q  <= CNT_W'(WIDTH - 1);
            busy_q <= 1'b1;
            dz_q   <= (b_i == '0);
        end else if (busy_q) begin
            quot_q <= quot_o;
            rem_q  <= rem_o;
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/arithm_seq.sv
// Multi-cycle arithmetic unit: single-cycle ADD/SUB, shift-add multiply and restoring divide
// over WIDTH iterations, with a valid/ready request side and a one-cycle result pulse.
module arithm_seq
    import arithm_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    arithm_seq_if.slave bus,
    output logic [1:0]  state_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] mcand_q, acc_q, mq_q, data_q;
    logic [CNT_W-1:0] cnt_q;
    flags_t           flags_q;

    logic             accept, is_sub;
    logic [WIDTH-1:0] b_eff, addend, acc_nx, mq_nx;
    logic [WIDTH:0]   sum, msum;
    logic             add_ovf;
    logic             div_busy, div_last, div_dz;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign accept = bus.i_valid && (state_q == ST_IDLE);

    always_comb begin
        is_sub  = (bus.i_op == ALU_SUB);
        b_eff   = is_sub ? ~bus.i_b : bus.i_b;
        sum     = {1'b0, bus.i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_ovf = (bus.i_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.i_a[WIDTH-1]);
        // {acc, mq} is the running 2*WIDTH product; each step adds and shifts right by one.
        addend  = mq_q[0] ? mcand_q : '0;
        msum    = {1'b0, acc_q} + {1'b0, addend};
        acc_nx  = msum[WIDTH:1];
        mq_nx   = {msum[0], mq_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (is_mul(bus.i_op))      state_d = ST_MUL;
                else if (is_div(bus.i_op)) state_d = ST_DIV;
                else                       state_d = ST_DONE;
            end
            ST_MUL:  if (cnt_q == '0) state_d = ST_DONE;
            ST_DIV:  if (div_last)    state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    arithm_divu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_divu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && is_div(bus.i_op)),
        .a_i     (bus.i_a),
        .b_i     (bus.i_b),
        .busy_o  (div_busy),
        .last_o  (div_last),
        .quot_o  (div_quot),
        .rem_o   (div_rem),
        .dz_o    (div_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q <= bus.i_op;
                    if (is_mul(bus.i_op)) begin
                        mcand_q <= bus.i_b;
                        mq_q    <= bus.i_a;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                    end else if (bus.i_op == ALU_ADD || bus.i_op == ALU_SUB) begin
                        data_q  <= sum[WIDTH-1:0];
                        flags_q <= '{cf: sum[WIDTH], ovf: add_ovf, dz: 1'b0};
                    end else if (!is_div(bus.i_op)) begin
                        data_q  <= '0;
                        flags_q <= '0;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_nx;
                    mq_q  <= mq_nx;
                    if (cnt_q == '0) begin
                        data_q  <= (op_q == ALU_MUL_H) ? acc_nx : mq_nx;
                        flags_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DIV: if (div_last) begin
                    data_q  <= (op_q == ALU_DIV) ? div_quot : div_rem;
                    flags_q <= '{cf: 1'b0, ovf: 1'b0, dz: div_dz};
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_valid = (state_q == ST_DONE);
    assign bus.o_data  = data_q;
    assign bus.o_cf    = flags_q.cf;
    assign bus.o_ovf   = flags_q.ovf;
    assign bus.o_dz    = flags_q.dz;
    assign state_o     = state_q;

    // div_busy mirrors ST_DIV; kept visible for checker binding.
    logic unused_busy;
    assign unused_busy = div_busy;
endmodule

// File: tb/tb_arithm_seq.sv
// Directed bench for arithm_seq at WIDTH=8 with hand-computed results, latencies and flags.
module tb_arithm_seq;
    import arithm_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    int         total;
    int         bad;

    arithm_seq_if #(.WIDTH(8)) bus ();

    arithm_seq #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the result pulse, then check the idle cycle that follows.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat, input logic [7:0] exp_d,
                         input logic ecf, input logic eovf, input logic edz, input bit hold);
        int n;
        int ready_hi;
        bit seen;
        n = 0;
        ready_hi = 0;
        seen = 0;
        @(negedge clk);
        check_val({tag, "_rdy_before"}, 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_valid) begin
                seen = 1;
                bus.i_valid = 1'b0;
            end else begin
                if (bus.o_ready) ready_hi++;
                if (hold) begin
                    bus.i_op = 3'($urandom_range(0, 7));
                    bus.i_a  = 8'($urandom_range(0, 255));
                    bus.i_b  = 8'($urandom_range(0, 255));
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
        end
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_busy_rdy"}, 32'(ready_hi), 32'd0);
        check_val({tag, "_data"}, 32'(bus.o_data), 32'(exp_d));
        check_val({tag, "_flags"}, {29'd0, bus.o_cf, bus.o_ovf, bus.o_dz}, {29'd0, ecf, eovf, edz});
        check_val({tag, "_rdy_done"}, 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        check_val({tag, "_pulse"}, {30'd0, bus.o_valid, bus.o_ready}, 32'b01);
        check_val({tag, "_hold"}, 32'(bus.o_data), 32'(exp_d));
    endtask

    initial begin
        int pulses;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_op = '0;
        bus.i_a = '0;
        bus.i_b = '0;
        repeat (3) @(negedge clk);
        check_val("rst_outs", {bus.o_ready, bus.o_valid, bus.o_cf, bus.o_ovf, bus.o_dz}, 32'b10000);
        check_val("rst_data", 32'(bus.o_data), 32'd0);
        check_val("rst_state", 32'(state), 32'(ST_IDLE));
        rst_n = 1'b1;

        do_op("add_ff_01",  ALU_ADD,   8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("add_7f_01",  ALU_ADD,   8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("sub_05_07",  ALU_SUB,   8'h05, 8'h07, 1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub_80_01",  ALU_SUB,   8'h80, 8'h01, 1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("sub_07_07",  ALU_SUB,   8'h07, 8'h07, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("mulh_ff_ff", ALU_MUL_H, 8'hFF, 8'hFF, 9, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("mull_ff_ff", ALU_MUL_L, 8'hFF, 8'hFF, 9, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mull_0d_0b", ALU_MUL_L, 8'h0D, 8'h0B, 9, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mulh_0d_0b", ALU_MUL_H, 8'h0D, 8'h0B, 9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("div_200_7",  ALU_DIV,   8'd200, 8'd7, 9, 8'd28, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("rem_200_7",  ALU_REM,   8'd200, 8'd7, 9, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        do_op("div_33_0",   ALU_DIV,   8'h33, 8'h00, 9, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("rem_33_0",   ALU_REM,   8'h33, 8'h00, 9, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort a DIV in its fourth busy cycle and make sure no result ever surfaces.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op = ALU_DIV;
        bus.i_a = 8'd200;
        bus.i_b = 8'd7;
        @(posedge clk);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            if (bus.o_valid) pulses++;
        end
        rst_n = 1'b0;
        #1;
        check_val("abort_outs", {bus.o_ready, bus.o_valid, bus.o_cf, bus.o_ovf, bus.o_dz}, 32'b10000);
        check_val("abort_data", 32'(bus.o_data), 32'd0);
        check_val("abort_state", 32'(state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check_val("abort_no_valid", 32'(pulses), 32'd0);

        do_op("add_12_34",  ALU_ADD,   8'h12, 8'h34, 1, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub_33_01",  ALU_SUB,   8'h33, 8'h01, 1, 8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("inv_6",      3'b110,    8'hAA, 8'h55, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("add_80_80",  ALU_ADD,   8'h80, 8'h80, 1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("inv_7",      3'b111,    8'hFF, 8'hFF, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
